// File: rtl/riscv_mpsoc_pkg.sv
// riscv_mpsoc_pkg: arbiter state, requester ID type and BIU burst encodings
package riscv_mpsoc_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} arb_state_t;
  localparam int MAX_NREQ = 4;
  typedef logic [$clog2(MAX_NREQ)-1:0] req_id_t;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, WRAP4 = 3'b010, INCR4 = 3'b011,
                         WRAP8 = 3'b100, INCR8 = 3'b101, WRAP16 = 3'b110, INCR16 = 3'b111;
  function automatic logic [4:0] biu_burst_len(input logic [2:0] t);
    return (t == WRAP4  || t == INCR4)  ? 5'd4  :
           (t == WRAP8  || t == INCR8)  ? 5'd8  :
           (t == WRAP16 || t == INCR16) ? 5'd16 : 5'd1;
  endfunction
endpackage

// File: rtl/riscv_arb_idfifo.sv
// riscv_arb_idfifo: DEPTH-entry in-order FIFO of issuing-requester tags
module riscv_arb_idfifo #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic         rst_ni,
  input  logic         clk_i,
  input  logic         push_i,
  input  logic [W-1:0] d_i,
  input  logic         pop_i,
  output logic [W-1:0] q_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  assign q_o     = mem[rp];
  assign full_o  = cnt == CW'(DEPTH);
  assign empty_o = cnt == '0;
  always_ff @(posedge clk_i)
    if (push_i) mem[wp] <= d_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_i) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop_i) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter: shares one BIU port among NREQ masters, routing responses in order.
// Define RISCV_BIU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module riscv_biu_arbiter
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int PLEN  = 64,
  parameter int NREQ  = 2,
  parameter int DEPTH = 2
) (
  input  logic                 rst_ni,
  input  logic                 clk_i,
  input  logic [NREQ-1:0]      req_stb_i,
  output logic [NREQ-1:0]      req_stb_ack_o,
  input  logic [NREQ*PLEN-1:0] req_adr_i,
  input  logic [NREQ*3-1:0]    req_size_i,
  input  logic [NREQ*3-1:0]    req_type_i,
  input  logic [NREQ-1:0]      req_lock_i,
  input  logic [NREQ*3-1:0]    req_prot_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ*XLEN-1:0] req_d_i,
  output logic [XLEN-1:0]      req_q_o,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic                 biu_stb_o,
  input  logic                 biu_stb_ack_i,
  output logic [PLEN-1:0]      biu_adri_o,
  output logic [2:0]           biu_size_o,
  output logic [2:0]           biu_type_o,
  output logic                 biu_lock_o,
  output logic [2:0]           biu_prot_o,
  output logic                 biu_we_o,
  output logic [XLEN-1:0]      biu_d_o,
  input  logic [XLEN-1:0]      biu_q_i,
  input  logic                 biu_ack_i,
  input  logic                 biu_err_i
);
  arb_state_t state;
  req_id_t owner, win, arb_win, pos, head_id;
  logic [NREQ-1:0] rot;
  logic win_vld, own_stb, acc, resp, last, full, empty;
  logic [2:0] head_type;
  logic [4:0] beats, rem;
`ifdef RISCV_BIU_ARB_FIXED_PRIO_EN
  assign rot     = req_stb_i;
  assign arb_win = pos;
`else
  req_id_t rr;
  logic [2:0] sum;
  assign rot     = NREQ'({req_stb_i, req_stb_i} >> rr);
  assign sum     = 3'(rr) + 3'(pos);
  assign arb_win = req_id_t'(sum >= 3'(NREQ) ? sum - 3'(NREQ) : sum);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rr <= '0;
    else if (acc) rr <= win == req_id_t'(NREQ - 1) ? '0 : win + 1'b1;
`endif
  always_comb begin
    pos        = '0;
    own_stb    = 1'b0;
    biu_adri_o = '0;
    biu_size_o = '0;
    biu_type_o = '0;
    biu_lock_o = 1'b0;
    biu_prot_o = '0;
    biu_we_o   = 1'b0;
    biu_d_o    = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) pos = req_id_t'(i);
    for (int i = 0; i < NREQ; i++)
      if (req_id_t'(i) == owner) own_stb = req_stb_i[i];
    win     = state == IDLE ? arb_win : owner;
    win_vld = state == IDLE ? |req_stb_i : own_stb;
    for (int i = 0; i < NREQ; i++)
      if (req_id_t'(i) == win) begin
        biu_adri_o = req_adr_i[i*PLEN +: PLEN];
        biu_size_o = req_size_i[i*3 +: 3];
        biu_type_o = req_type_i[i*3 +: 3];
        biu_lock_o = req_lock_i[i];
        biu_prot_o = req_prot_i[i*3 +: 3];
        biu_we_o   = req_we_i[i];
        biu_d_o    = req_d_i[i*XLEN +: XLEN];
      end
  end
  // Gated by rst_ni so nothing reaches the BIU while reset is asserted.
  assign biu_stb_o = rst_ni & win_vld & ~full;
  assign acc       = biu_stb_o & biu_stb_ack_i;
  assign resp      = (biu_ack_i | biu_err_i) & ~empty;
  assign rem       = beats == '0 ? biu_burst_len(head_type) - 5'd1 : beats - 5'd1;
  assign last      = biu_err_i | rem == '0;
  assign req_q_o   = biu_q_i;
  always_comb
    for (int i = 0; i < NREQ; i++) begin
      req_stb_ack_o[i] = acc & (win == req_id_t'(i));
      req_ack_o[i]     = biu_ack_i & ~empty & (head_id == req_id_t'(i));
      req_err_o[i]     = biu_err_i & ~empty & (head_id == req_id_t'(i));
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      owner <= '0;
      beats <= '0;
    end else begin
      if (acc) begin
        state <= biu_lock_o ? LOCKED : IDLE;
        owner <= win;
      end else if (state == IDLE && biu_stb_o) begin
        state <= GRANT;
        owner <= win;
      end else if (state == GRANT && !own_stb) state <= IDLE;
      if (resp) beats <= last ? '0 : rem;
    end
  riscv_arb_idfifo #(.W(3 + $bits(req_id_t)), .DEPTH(DEPTH)) u_idfifo (
    .rst_ni  (rst_ni),
    .clk_i   (clk_i),
    .push_i  (acc),
    .d_i     ({biu_type_o, win}),
    .pop_i   (resp & last),
    .q_o     ({head_type, head_id}),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// tb_riscv_biu_arbiter: directed checks of arbitration, grant hold, lock, FIFO routing and reset
module tb_riscv_biu_arbiter;
  logic         rst_ni = 1'b0, clk_i = 1'b0;
  logic [1:0]   req_stb_i = '0, req_stb_ack_o, req_lock_i = '0, req_we_i = '0;
  logic [127:0] req_adr_i = {64'h2000, 64'h1000};
  logic [5:0]   req_size_i = {3'd2, 3'd3}, req_type_i = '0, req_prot_i = '0;
  logic [127:0] req_d_i = {64'hBBBB, 64'hAAAA};
  logic [63:0]  req_q_o, biu_adri_o, biu_d_o, biu_q_i = '0;
  logic [1:0]   req_ack_o, req_err_o;
  logic         biu_stb_o, biu_stb_ack_i = 1'b0, biu_lock_o, biu_we_o, biu_ack_i = 1'b0, biu_err_i = 1'b0;
  logic [2:0]   biu_size_o, biu_type_o, biu_prot_o;
  int errors = 0, checks = 0;

  riscv_biu_arbiter dut (
    .rst_ni(rst_ni), .clk_i(clk_i),
    .req_stb_i(req_stb_i), .req_stb_ack_o(req_stb_ack_o), .req_adr_i(req_adr_i),
    .req_size_i(req_size_i), .req_type_i(req_type_i), .req_lock_i(req_lock_i),
    .req_prot_i(req_prot_i), .req_we_i(req_we_i), .req_d_i(req_d_i), .req_q_o(req_q_o),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .biu_stb_o(biu_stb_o),
    .biu_stb_ack_i(biu_stb_ack_i), .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o),
    .biu_type_o(biu_type_o), .biu_lock_o(biu_lock_o), .biu_prot_o(biu_prot_o),
    .biu_we_o(biu_we_o), .biu_d_o(biu_d_o), .biu_q_i(biu_q_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [1:0] stb, input logic sack, input logic ack, input logic err);
    req_stb_i = stb;
    biu_stb_ack_i = sack;
    biu_ack_i = ack;
    biu_err_i = err;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    drv(2'b11, 1, 1, 0);
    chk("rst_stb", 64'(biu_stb_o), 0);
    chk("rst_stb_ack", 64'(req_stb_ack_o), 0);
    chk("rst_ack", 64'(req_ack_o), 0);
    step();
    rst_ni = 1'b1;
    drv(2'b11, 1, 0, 0);
    chk("rr0_adr", biu_adri_o, 64'h1000);
    chk("rr0_stb_ack", 64'(req_stb_ack_o), 64'b01);
    step();
    drv(2'b11, 1, 1, 0);
    chk("rr1_adr", biu_adri_o, 64'h2000);
    chk("rr1_stb_ack", 64'(req_stb_ack_o), 64'b10);
    chk("rr1_ack", 64'(req_ack_o), 64'b01);
    step();
    drv(2'b11, 1, 1, 0);
    chk("rr2_stb_ack", 64'(req_stb_ack_o), 64'b01);
    chk("rr2_ack", 64'(req_ack_o), 64'b10);
    step();
    drv(2'b11, 1, 1, 0);
    chk("rr3_stb_ack", 64'(req_stb_ack_o), 64'b10);
    chk("rr3_ack", 64'(req_ack_o), 64'b01);
    step();
    drv(2'b00, 0, 1, 0);
    chk("rr_drain_stb", 64'(biu_stb_o), 0);
    chk("rr_drain_ack", 64'(req_ack_o), 64'b10);
    step();
    drv(2'b01, 0, 0, 0);
    chk("hold_stb", 64'(biu_stb_o), 1);
    chk("hold_adr0", biu_adri_o, 64'h1000);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(2'b11, 0, 0, 0);
      chk("hold_adr", biu_adri_o, 64'h1000);
      chk("hold_stb_ack", 64'(req_stb_ack_o), 0);
      step();
    end
    drv(2'b11, 1, 0, 0);
    chk("hold_accept", 64'(req_stb_ack_o), 64'b01);
    step();
    drv(2'b10, 1, 0, 0);
    chk("fill_adr", biu_adri_o, 64'h2000);
    chk("fill_stb_ack", 64'(req_stb_ack_o), 64'b10);
    step();
    drv(2'b11, 0, 0, 0);
    chk("full_stall", 64'(biu_stb_o), 0);
    step();
    biu_q_i = 64'h1234;
    drv(2'b11, 0, 1, 0);
    chk("full_ack", 64'(req_ack_o), 64'b01);
    chk("full_q", req_q_o, 64'h1234);
    chk("full_still_stall", 64'(biu_stb_o), 0);
    step();
    drv(2'b11, 0, 0, 0);
    chk("full_restart", 64'(biu_stb_o), 1);
    chk("full_restart_adr", biu_adri_o, 64'h1000);
    step();
    drv(2'b00, 0, 1, 0);
    chk("flush_stb", 64'(biu_stb_o), 0);
    chk("flush_ack", 64'(req_ack_o), 64'b10);
    step();
    req_lock_i = 2'b10;
    drv(2'b10, 1, 0, 0);
    chk("lock_o", 64'(biu_lock_o), 1);
    chk("lock_stb_ack", 64'(req_stb_ack_o), 64'b10);
    step();
    drv(2'b11, 1, 1, 0);
    chk("locked_block", 64'(req_stb_ack_o), 64'b10);
    chk("locked_ack", 64'(req_ack_o), 64'b10);
    step();
    req_lock_i = 2'b00;
    drv(2'b11, 0, 0, 0);
    chk("locked_adr", biu_adri_o, 64'h2000);
    step();
    drv(2'b11, 1, 1, 0);
    chk("unlock_stb_ack", 64'(req_stb_ack_o), 64'b10);
    chk("unlock_lock_o", 64'(biu_lock_o), 0);
    step();
    drv(2'b11, 1, 1, 0);
    chk("after_lock_win0", 64'(req_stb_ack_o), 64'b01);
    chk("after_lock_ack", 64'(req_ack_o), 64'b10);
    step();
    drv(2'b00, 0, 1, 0);
    chk("lock_drain", 64'(req_ack_o), 64'b01);
    step();
    drv(2'b01, 1, 0, 0);
    chk("ooo_rd", 64'(req_stb_ack_o), 64'b01);
    chk("ooo_rd_we", 64'(biu_we_o), 0);
    step();
    req_we_i = 2'b10;
    drv(2'b10, 1, 0, 0);
    chk("ooo_wr", 64'(req_stb_ack_o), 64'b10);
    chk("ooo_wr_we", 64'(biu_we_o), 1);
    chk("ooo_wr_d", biu_d_o, 64'hBBBB);
    step();
    req_we_i = 2'b00;
    biu_q_i = 64'hDEAD;
    drv(2'b00, 0, 1, 0);
    chk("ooo_ack0", 64'(req_ack_o), 64'b01);
    chk("ooo_q", req_q_o, 64'hDEAD);
    step();
    drv(2'b00, 0, 0, 1);
    chk("ooo_err1", 64'(req_err_o), 64'b10);
    chk("ooo_err_noack", 64'(req_ack_o), 0);
    step();
    drv(2'b00, 0, 1, 1);
    chk("spur_ack", 64'(req_ack_o), 0);
    chk("spur_err", 64'(req_err_o), 0);
    step();
    drv(2'b01, 1, 0, 0);
    chk("post_spur_issue", 64'(req_stb_ack_o), 64'b01);
    step();
    drv(2'b00, 0, 1, 0);
    chk("post_spur_ack", 64'(req_ack_o), 64'b01);
    step();
    req_type_i = {3'b011, 3'b011};
    drv(2'b10, 1, 0, 0);
    chk("burst_type", 64'(biu_type_o), 64'd3);
    chk("burst_stb_ack", 64'(req_stb_ack_o), 64'b10);
    step();
    for (int i = 0; i < 4; i++) begin
      drv(2'b00, 0, 1, 0);
      chk("burst_beat", 64'(req_ack_o), 64'b10);
      step();
    end
    drv(2'b00, 0, 1, 0);
    chk("burst_done", 64'(req_ack_o), 0);
    step();
    drv(2'b01, 1, 0, 0);
    chk("rb_issue", 64'(req_stb_ack_o), 64'b01);
    step();
    drv(2'b00, 0, 1, 0);
    chk("rb_beat", 64'(req_ack_o), 64'b01);
    step();
    drv(2'b11, 0, 1, 0);
    chk("rb_beat2", 64'(req_ack_o), 64'b01);
    rst_ni = 1'b0;
    #1;
    chk("rb_rst_stb", 64'(biu_stb_o), 0);
    chk("rb_rst_ack", 64'(req_ack_o), 0);
    chk("rb_rst_stb_ack", 64'(req_stb_ack_o), 0);
    step();
    rst_ni = 1'b1;
    req_type_i = '0;
    drv(2'b00, 0, 1, 0);
    chk("rb_spur", 64'(req_ack_o), 0);
    step();
    drv(2'b11, 1, 0, 0);
    chk("rb_ptr0", 64'(req_stb_ack_o), 64'b01);
    chk("rb_adr", biu_adri_o, 64'h1000);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_biu_arbiter.md
Name: riscv_biu_arbiter

Overview:
- Shares one BIU port between NREQ external-access masters: data ext, instruction ext, and optionally a page-table walker.
- Each requester uses the same stb/stb_ack + ack/err handshake that the BIU presents.
- Arbitrates address phases, holds the grant stable until the BIU accepts it, and supports locked sequences.
- Routes pipelined data responses back to the issuing requester through an in-order owner-ID FIFO.

Parameters:
XLEN, 64, data width
PLEN, 64, physical address width
NREQ, 2, number of requesters (2..4)
DEPTH, 2, max address phases accepted but not yet answered

Ports:
rst_ni  in  1  asynchronous reset, active-low
clk_i  in  1  clock
req_stb_i  in  NREQ  per-requester address-phase request
req_stb_ack_o  out  NREQ  per-requester address accepted by BIU
req_adr_i  in  NREQ*PLEN  address, packed by requester index
req_size_i  in  NREQ*3  transfer size
req_type_i  in  NREQ*3  burst type
req_lock_i  in  NREQ  locked-transfer flag
req_prot_i  in  NREQ*3  protection
req_we_i  in  NREQ  write enable
req_d_i  in  NREQ*XLEN  write data
req_q_o  out  XLEN  read data, broadcast to all requesters
req_ack_o  out  NREQ  per-requester data acknowledge
req_err_o  out  NREQ  per-requester data error
biu_stb_o  out  1  request to BIU
biu_stb_ack_i  in  1  BIU accepted address
biu_adri_o  out  PLEN  address
biu_size_o  out  3  size
biu_type_o  out  3  burst type
biu_lock_o  out  1  lock
biu_prot_o  out  3  protection
biu_we_o  out  1  write enable
biu_d_o  out  XLEN  write data
biu_q_i  in  XLEN  read data
biu_ack_i  in  1  data acknowledge, one per beat
biu_err_i  in  1  data error

Behaviour:
- Reset state:
  - Owner invalid, round-robin pointer 0, lock clear, FIFO empty.
  - biu_stb_o=0; all req_stb_ack_o, req_ack_o and req_err_o are 0.
- Arbitration state machine: IDLE, GRANT, LOCKED.
  - IDLE: winner is selected combinationally from req_stb_i. Round-robin starts at the pointer. biu_stb_o is asserted in the same cycle, giving zero latency.
  - IDLE -> GRANT: winner stored in the owner register when biu_stb_ack_i=0.
  - GRANT: the mux is frozen on the owner; no re-arbitration while the address phase is pending.
  - GRANT -> IDLE: on biu_stb_ack_i, or when the owner drops req_stb_i (clear/flush).
  - Any accepted phase with lock=1 -> LOCKED with owner kept.
  - LOCKED: only the owner may issue. Exits to IDLE when the owner's phase with lock=0 is accepted.
- Round-robin pointer: on every accepted phase, pointer <= winner+1 mod NREQ.
- Address-phase gating:
  - biu_stb_o = (winner valid) & ~fifo_full.
  - req_stb_ack_o[owner] = biu_stb_ack_i. All other stb_ack bits are 0.
- Owner-ID FIFO, width clog2(NREQ), DEPTH entries:
  - Push winner ID on biu_stb_ack_i; pop on biu_ack_i|biu_err_i.
  - Simultaneous push and pop leaves the count unchanged.
  - No push can occur when full because stb is gated.
- Response routing:
  - req_ack_o[head]=biu_ack_i and req_err_o[head]=biu_err_i; req_q_o=biu_q_i.
  - Same cycle; ack to the head ID only.
- Spurious ack/err with FIFO empty: dropped; no req_ack_o; FIFO count stays 0.
- Burst type != SINGLE: the FIFO pops only on the last beat. A beat counter is loaded from the burst length of the head entry; each intermediate beat is forwarded to the head ID.
- Reset mid-transfer: all state cleared asynchronously; outstanding BIU responses after reset are treated as spurious.

Optional Feature:
- Macro: RISCV_BIU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index wins, so data ext on index 0 beats instruction ext. The pointer is unused and removed.
- Undefined: round-robin as described above.
- LOCKED and GRANT semantics are identical in both modes.

Decomposition:
- riscv_mpsoc_pkg holds:
  - the arbiter state enum (IDLE/GRANT/LOCKED);
  - the requester ID typedef logic [$clog2(NREQ)-1:0];
  - the burst-type constants (SINGLE, INCR4, WRAP4, ...) and burst-length function already used by the BIU.
- One sub-module: riscv_arb_idfifo, a synchronous DEPTH-entry ID FIFO with push/pop/full/empty/head.

Test Plan:
- Round-robin: both stb high, BIU acks every cycle -> grants go 0,1,0,1. Each req_stb_ack_o fires once per accept; FIFO IDs match.
- Grant hold: req0 wins, biu_stb_ack_i low for 3 cycles while req1 asserts -> biu_adri_o stays req0 address (0x1000) for all 3 cycles; req1 waits.
- Full stall: DEPTH=2, two phases accepted, no ack -> biu_stb_o=0. One biu_ack_i -> req_ack_o routed to the first ID, then biu_stb_o reasserts next cycle.
- Lock: req1 issues lock=1 while req0 is requesting -> req0 blocked until req1's lock=0 phase is accepted; then req0 is granted.
- Out-of-order owners: accept req0 (read) then req1 (write); ack with q=0xDEAD then ack -> req_ack_o[0] with q=0xDEAD, then req_ack_o[1]. biu_err_i on the second response -> req_err_o[1] only.
- Spurious/reset: biu_ack_i with FIFO empty -> no req_ack_o. Assert rst_ni=0 mid-burst -> all outputs 0 immediately; state is IDLE after release.
